sel2_arb: RTL and testbench
===========================

# sel2_arb

Two-requester round-robin arbiter that owns the select line of a WIDTH-bit 2:1 selector and shares one registered output path between requester A and requester B. Each requester holds the path for a burst of up to MAX_BURST transfers, after which a waiting competitor takes over. The block sits in front of the 2:1 selector datapath. It replaces a free-running SEL input with a sequenced, fair grant.

## Interface
- WIDTH, 1: data width of A, B, OUT.
- MAX_BURST, 4: maximum consecutive grant cycles per ownership, legal range 1..15.

- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- REQ_A  in  1  requester A wants the path (level)
- REQ_B  in  1  requester B wants the path (level)
- A  in  WIDTH  data from requester A
- B  in  WIDTH  data from requester B
- GNT_A  out  1  A owns the path this cycle
- GNT_B  out  1  B owns the path this cycle
- SEL  out  1  selector control: 0 = A, 1 = B
- OUT  out  WIDTH  registered selected data
- OUT_VLD  out  1  OUT carries a transfer this cycle

## Operation
- FSM states: IDLE, OWN_A, OWN_B. GNT_A = (state == OWN_A) and GNT_B = (state == OWN_B), both registered (Moore).
- SEL = 1 in OWN_B and 0 in OWN_A. In IDLE, SEL holds its last value.
- LAST flag records the last served requester. The reset value is B, so A wins the first tie.
- BCNT is a 4-bit burst counter. It clears on every entry into OWN_x and increments on each cycle in OWN_x.
- From IDLE:
  - Both requesting: go to OWN of the requester that is not LAST.
  - One requesting: go to that requester's OWN state.
  - None requesting: stay in IDLE.
- From OWN_x, the burst ends when REQ_x = 0 or BCNT == MAX_BURST-1. At burst end:
  - If the other requester is requesting, go directly to OWN_other with no idle bubble.
  - Else if REQ_x = 1 (burst expired, no competitor), re-enter OWN_x and clear BCNT.
  - Else go to IDLE.
- LAST updates to x on every exit from OWN_x.
- Transfer happens on a cycle with GNT_x = 1 and REQ_x = 1. At the next edge OUT captures x's data and OUT_VLD goes to 1. A non-transfer cycle sets OUT_VLD to 0 and leaves OUT holding its value.
- Requesters present data in the same cycle that they see their GNT with their REQ high.

## Timing
- Reset values: state IDLE, GNT_A = 0, GNT_B = 0, SEL = 0, OUT = 0, OUT_VLD = 0, BCNT = 0, LAST = B.
- Latency:
  - REQ rises in cycle n while IDLE: GNT in cycle n+1.
  - First OUT_VLD in cycle n+2.
  - Grant handover between requesters costs 0 bubble cycles.
- A grant lasts at most MAX_BURST consecutive cycles while the other requester waits. The worst-case wait for a requester is MAX_BURST+1 cycles.
- A dropping REQ_x in a grant cycle does the following: that cycle is not a transfer, and the state leaves OWN_x at the next edge.
- MAX_BURST = 1: strict alternation whenever both requesters request.
- An RST_N assertion mid-burst clears everything immediately (asynchronously). The first grant after release follows the IDLE rules with LAST = B.

## Structure
- Package sel2_arb_pkg holds:
  - The state enum (IDLE = 2'b00, OWN_A = 2'b01, OWN_B = 2'b10).
  - The constants SEL_A = 0, SEL_B = 1.
  - BCNT_W = 4.
- Sub-module sel2_1_w: a WIDTH-bit combinational 2:1 selector with OUT = SEL ? B : A, instantiated once. It feeds the OUT register.
- The FSM, BCNT, LAST and the output register live in sel2_arb.

## Test plan
- Reset: hold RST_N = 0 with REQ_A = REQ_B = 1 → all outputs at their reset values. Release → GNT_A = 1 the next cycle.
- Single requester: REQ_A = 1 for 3 cycles with A = 1, 0, 1 → GNT_A for 3 cycles, then OUT_VLD for 3 cycles with OUT = 1, 0, 1, then IDLE.
- Contention with MAX_BURST = 4: both REQ held high → GNT_A for 4 cycles, GNT_B for 4, GNT_A for 4. SEL toggles with no gap, and OUT_VLD stays at 1 continuously after its first assertion.
- Early release: both REQ high, REQ_A drops in its 2nd grant cycle → exactly 1 transfer from A, then GNT_B in the next cycle. LAST = A.
- Solo expiry with MAX_BURST = 2: only REQ_B = 1 for 6 cycles → GNT_B stays high. BCNT wraps 0, 1, 0, 1 and 6 transfers from B occur.
- Reset mid-burst: assert RST_N low in the 2nd cycle of OWN_B → GNT_B = 0, OUT_VLD = 0 and SEL = 0 immediately. After release with both REQ high, A is granted first.

Source files
------------

// File: rtl/sel2_arb_pkg.sv
// Shared types and constants for the two-requester
// round-robin arbiter.
package sel2_arb_pkg;

    localparam int BCNT_W = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_e;

endpackage

// File: rtl/sel2_1_w.sv
// WIDTH-bit combinational 2:1 selector.
// sel = 0 picks a, sel = 1 picks b.
module sel2_1_w #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/sel2_arb.sv
// Round-robin arbiter owning the select of a 2:1 selector
// with bounded bursts and a registered output path.
module sel2_arb
    import sel2_arb_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             SEL,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VLD
);

    localparam logic [BCNT_W-1:0] BMAX = BCNT_W'(MAX_BURST - 1);

    state_e             state_q, state_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic               last_q, last_d;
    logic               sel_q, sel_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_vld_q, out_vld_d;
    logic               xfer;
    logic [WIDTH-1:0]   mux_y;

    sel2_1_w #(.WIDTH(WIDTH)) u_mux (
        .sel (sel_q),
        .a   (A),
        .b   (B),
        .y   (mux_y)
    );

    // Next state, burst counter, fairness flag and output path
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        xfer    = 1'b0;
        unique case (state_q)
            IDLE: begin
                bcnt_d = '0;
                if (REQ_A && REQ_B) begin
                    state_d = (last_q == SEL_A) ? OWN_B : OWN_A;
                end else if (REQ_A) begin
                    state_d = OWN_A;
                end else if (REQ_B) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                xfer = REQ_A;
                if (!REQ_A || bcnt_q == BMAX) begin
                    last_d = SEL_A;
                    bcnt_d = '0;
                    if (REQ_B) begin
                        state_d = OWN_B;
                    end else if (REQ_A) begin
                        state_d = OWN_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            OWN_B: begin
                xfer = REQ_B;
                if (!REQ_B || bcnt_q == BMAX) begin
                    last_d = SEL_B;
                    bcnt_d = '0;
                    if (REQ_A) begin
                        state_d = OWN_A;
                    end else if (REQ_B) begin
                        state_d = OWN_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
            end
        endcase
        if (state_d == OWN_A) begin
            sel_d = SEL_A;
        end else if (state_d == OWN_B) begin
            sel_d = SEL_B;
        end
        out_d     = xfer ? mux_y : out_q;
        out_vld_d = xfer;
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            last_q    <= SEL_B;
            sel_q     <= SEL_A;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign GNT_A   = (state_q == OWN_A);
    assign GNT_B   = (state_q == OWN_B);
    assign SEL     = sel_q;
    assign OUT     = out_q;
    assign OUT_VLD = out_vld_q;

endmodule

// File: tb/tb_sel2_arb.sv
// Directed bench for sel2_arb: reset, single requester,
// contention, early release, solo expiry, reset mid-burst.
module tb_sel2_arb;
    import sel2_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b;
    logic [0:0] a, b;
    logic       gnt_a, gnt_b, sel, out_vld;
    logic [0:0] out;

    logic       req_a2, req_b2;
    logic [0:0] a2, b2;
    logic       gnt_a2, gnt_b2, sel2, vld2;
    logic [0:0] out2;

    int total = 0;
    int bad   = 0;

    sel2_arb #(.WIDTH(1), .MAX_BURST(4)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ_A(req_a), .REQ_B(req_b),
        .A(a), .B(b),
        .GNT_A(gnt_a), .GNT_B(gnt_b),
        .SEL(sel), .OUT(out), .OUT_VLD(out_vld)
    );

    sel2_arb #(.WIDTH(1), .MAX_BURST(2)) dut2 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_A(req_a2), .REQ_B(req_b2),
        .A(a2), .B(b2),
        .GNT_A(gnt_a2), .GNT_B(gnt_b2),
        .SEL(sel2), .OUT(out2), .OUT_VLD(vld2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_a  = 1'b0; req_b  = 1'b0;
        a      = 1'b0; b      = 1'b0;
        req_a2 = 1'b0; req_b2 = 1'b0;
        a2     = 1'b0; b2     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // reset held with both requests high
        rst_n = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        a = 1'b1; b = 1'b1;
        req_a2 = 1'b0; req_b2 = 1'b0;
        a2 = 1'b0; b2 = 1'b0;
        tick();
        tick();
        chk("rst_gnt_a", 32'(gnt_a), 0);
        chk("rst_gnt_b", 32'(gnt_b), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_vld", 32'(out_vld), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_gnt_a", 32'(gnt_a), 1);
        chk("rel_gnt_b", 32'(gnt_b), 0);

        // single requester A, data 1,0,1
        do_reset();
        req_a = 1'b1;
        tick();
        chk("s_gnt1", 32'(gnt_a), 1);
        chk("s_vld0", 32'(out_vld), 0);
        a = 1'b1;
        tick();
        chk("s_out1", 32'(out), 1);
        chk("s_vld1", 32'(out_vld), 1);
        a = 1'b0;
        tick();
        chk("s_out2", 32'(out), 0);
        chk("s_vld2", 32'(out_vld), 1);
        a = 1'b1;
        tick();
        chk("s_out3", 32'(out), 1);
        chk("s_vld3", 32'(out_vld), 1);
        req_a = 1'b0;
        a = 1'b0;
        tick();
        chk("s_idle_gnt", 32'(gnt_a), 0);
        chk("s_idle_vld", 32'(out_vld), 0);
        chk("s_hold_out", 32'(out), 1);

        // contention, MAX_BURST = 4
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        a = 1'b1; b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            automatic logic own_a = (i < 4) || (i >= 8);
            automatic logic prv_a = (i < 5) || (i >= 9);
            tick();
            chk($sformatf("c_gnt_a%0d", i), 32'(gnt_a), 32'(own_a));
            chk($sformatf("c_gnt_b%0d", i), 32'(gnt_b), 32'(!own_a));
            chk($sformatf("c_sel%0d", i), 32'(sel), 32'(!own_a));
            chk($sformatf("c_vld%0d", i), 32'(out_vld), 32'(i > 0));
            if (i > 0) begin
                chk($sformatf("c_out%0d", i), 32'(out), 32'(prv_a));
            end
        end

        // early release by A in its second grant cycle
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        a = 1'b1; b = 1'b0;
        tick();
        chk("e_gnt_a", 32'(gnt_a), 1);
        tick();
        chk("e_gnt_a2", 32'(gnt_a), 1);
        chk("e_vld1", 32'(out_vld), 1);
        chk("e_out1", 32'(out), 1);
        req_a = 1'b0;
        tick();
        chk("e_gnt_b", 32'(gnt_b), 1);
        chk("e_gnt_a_off", 32'(gnt_a), 0);
        chk("e_vld2", 32'(out_vld), 0);
        chk("e_sel", 32'(sel), 1);
        chk("e_last", 32'(dut.last_q), 32'(SEL_A));
        tick();
        chk("e_vldb", 32'(out_vld), 1);
        chk("e_outb", 32'(out), 0);

        // solo expiry on the MAX_BURST = 2 instance
        do_reset();
        req_b2 = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            automatic logic v = 1'(i % 2 == 0);
            chk($sformatf("x_gnt%0d", i), 32'(gnt_b2), 1);
            chk($sformatf("x_bcnt%0d", i), 32'(dut2.bcnt_q), 32'(i % 2));
            b2 = v;
            tick();
            chk($sformatf("x_vld%0d", i), 32'(vld2), 1);
            chk($sformatf("x_out%0d", i), 32'(out2), 32'(v));
        end
        chk("x_gnt_a", 32'(gnt_a2), 0);

        // asynchronous reset in the second OWN_B cycle
        do_reset();
        req_b = 1'b1; b = 1'b1;
        tick();
        chk("r_gnt_b1", 32'(gnt_b), 1);
        tick();
        chk("r_gnt_b2", 32'(gnt_b), 1);
        chk("r_sel_b", 32'(sel), 1);
        chk("r_vld_b", 32'(out_vld), 1);
        rst_n = 1'b0;
        #1;
        chk("r_gnt_b0", 32'(gnt_b), 0);
        chk("r_vld0", 32'(out_vld), 0);
        chk("r_sel0", 32'(sel), 0);
        req_a = 1'b1; req_b = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        chk("r_gnt_a", 32'(gnt_a), 1);
        chk("r_gnt_b", 32'(gnt_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
